// File: rtl/gcd_engine.sv
// Self-sequencing GCD engine: subtractive Euclid or binary Stein, chosen per operation,
// with valid/ready handshakes on operands and results and a saturating iteration count.
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] xin,
  input  logic [WIDTH-1:0] yin,
  input  logic             mode,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd,
  output logic [CNT_W-1:0] cycles
);

  localparam int KW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SUB, BIN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] x, y, x_nx, y_nx, gcd_nx;
  logic [KW-1:0]    k, k_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cycles_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      x      <= '0;
      y      <= '0;
      k      <= '0;
      cnt    <= '0;
      gcd    <= '0;
      cycles <= '0;
    end else begin
      x      <= x_nx;
      y      <= y_nx;
      k      <= k_nx;
      cnt    <= cnt_nx;
      gcd    <= gcd_nx;
      cycles <= cycles_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    x_nx      = x;
    y_nx      = y;
    k_nx      = k;
    cnt_nx    = cnt;
    gcd_nx    = gcd;
    cycles_nx = cycles;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          x_nx   = xin;
          y_nx   = yin;
          k_nx   = '0;
          cnt_nx = '0;
          // A zero operand needs no iteration; OR-ing gives the other operand (or 0).
          if (xin == '0 || yin == '0) begin
            gcd_nx    = xin | yin;
            cycles_nx = '0;
            state_nx  = DONE;
          end else begin
            state_nx = mode ? BIN : SUB;
          end
        end
      end
      SUB: begin
        cnt_nx = sat_inc(cnt);
        if (abort) begin
          state_nx = IDLE;
        end else if (x == y) begin
          gcd_nx    = x;
          cycles_nx = sat_inc(cnt);
          state_nx  = DONE;
        end else if (x > y) begin
          x_nx = x - y;
        end else begin
          y_nx = y - x;
        end
      end
      BIN: begin
        cnt_nx = sat_inc(cnt);
        if (abort) begin
          state_nx = IDLE;
        end else if (x == y) begin
          // Restore the common power of two stripped while both were even.
          gcd_nx    = x << k;
          cycles_nx = sat_inc(cnt);
          state_nx  = DONE;
        end else if (!x[0] && !y[0]) begin
          x_nx = x >> 1;
          y_nx = y >> 1;
          k_nx = k + KW'(1);
        end else if (!x[0]) begin
          x_nx = x >> 1;
        end else if (!y[0]) begin
          y_nx = y >> 1;
        end else if (x > y) begin
          x_nx = (x - y) >> 1;
        end else begin
          y_nx = (y - x) >> 1;
        end
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
